// File: rtl/peripheral_ahb3_sram_slave.sv
// rtl/peripheral_ahb3_sram_slave.sv - AHB3-Lite word-array SRAM slave with wait states and ERROR response
module peripheral_ahb3_sram_slave #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [HADDR_SIZE-1:0] haddr,
  input  logic [HDATA_SIZE-1:0] hwdata,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [1:0]            htrans,
  input  logic                  hmastlock,
  input  logic                  hready,
  output logic [HDATA_SIZE-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [AW+1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [HDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  logic                  sample, accept, legal, misaligned, out_of_range;
  logic                  mem_we;
  logic [3:0]            lane_mask;
  logic [AW-1:0]         widx;
  logic [HDATA_SIZE-1:0] wr_word;
  logic                  unused_ok;

  assign unused_ok = ^{hburst, hprot, hmastlock};
  assign widx      = addr_q[AW+1:2];

  // A new address phase is only looked at while the bus is not being stalled by us.
  assign sample = (state_q == ST_IDLE) || (state_q == ST_ERR2) ||
                  ((state_q == ST_DATA) && (wcnt_q == 4'd0));
  assign accept = sample && hsel && hready && htrans[1];

  always_comb begin
    misaligned   = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    out_of_range = |haddr[HADDR_SIZE-1:AW+2];
    legal        = (hsize <= 3'd2) && !misaligned && !out_of_range;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      ST_DATA: begin
        if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
        else                state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d = legal ? ST_DATA : ST_ERR1;
      wcnt_d  = legal ? WS : 4'd0;
      addr_d  = haddr[AW+1:0];
      write_d = hwrite;
      size_d  = hsize;
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    mem_we    = 1'b0;
    case (state_q)
      ST_DATA: begin
        hreadyout = (wcnt_q == 4'd0);
        if (wcnt_q == 4'd0) begin
          if (write_q) mem_we = 1'b1;
          else         hrdata = mem_q[widx];
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  // Little-endian byte lanes; untouched lanes keep the stored word.
  always_comb begin
    case (size_q)
      3'd0:    lane_mask = 4'b0001 << addr_q[1:0];
      3'd1:    lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
    wr_word = mem_q[widx];
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) wr_word[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    if (mem_we) mem_q[widx] <= wr_word;
  end

endmodule

// File: tb/tb_peripheral_ahb3_sram_slave.sv
// tb/tb_peripheral_ahb3_sram_slave.sv - table, directed and randomized checks of the AHB3 SRAM slave
module tb_peripheral_ahb3_sram_slave;
  localparam int NDUT  = 3;
  localparam int DEPTH = 256;

  typedef struct {
    bit        sel;
    bit        hrdy_lo;
    bit [1:0]  trans;
    bit        wr;
    bit [2:0]  size;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit        exp_err;
    bit [31:0] exp_rdata;
  } vec_t;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        sel_b, ovr_lo, hwrite, hmastlock;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  int          tgt;

  logic [31:0] hrdata_v    [NDUT];
  logic        hreadyout_v [NDUT];
  logic        hresp_v     [NDUT];
  logic        hready_v    [NDUT];
  logic        hsel_v      [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign hsel_v[g]   = sel_b && (tgt == g);
    assign hready_v[g] = ovr_lo ? 1'b0 : hreadyout_v[g];
    peripheral_ahb3_sram_slave #(
      .HADDR_SIZE(32), .HDATA_SIZE(32), .MEM_DEPTH(DEPTH),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[g]), .haddr(haddr), .hwdata(hwdata),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
      .hmastlock(hmastlock), .hready(hready_v[g]), .hrdata(hrdata_v[g]),
      .hreadyout(hreadyout_v[g]), .hresp(hresp_v[g])
    );
  end

  always #5 hclk = ~hclk;

  bit [31:0] mmem [NDUT][DEPTH];
  bit        mok  [NDUT][DEPTH];
  int        errors = 0;
  int        checks = 0;
  vec_t      xq[$];
  logic [31:0] obs_rdata;
  logic        obs_err;
  int          obs_low;

  function automatic int ws_of(int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic bit is_legal(vec_t v);
    if (v.size > 2) return 1'b0;
    if ((v.addr % (32'd1 << v.size)) != 0) return 1'b0;
    if ((v.addr / 4) >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  function automatic vec_t mk(bit sel, bit lo, bit [1:0] trans, bit wr, bit [2:0] size,
                              bit [31:0] addr, bit [31:0] wdata, bit err, bit [31:0] rdata);
    vec_t v;
    v.sel = sel; v.hrdy_lo = lo; v.trans = trans; v.wr = wr; v.size = size;
    v.addr = addr; v.wdata = wdata; v.exp_err = err; v.exp_rdata = rdata;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chkb(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic idle_bus();
    sel_b = 1'b0; ovr_lo = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
  endtask

  task automatic model_write(vec_t v);
    int idx   = int'(v.addr / 4);
    int first = int'(v.addr % 4);
    int n     = 1 << v.size;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + n) mmem[tgt][idx][8*b +: 8] = v.wdata[8*b +: 8];
    if (n == 4) mok[tgt][idx] = 1'b1;
  endtask

  // Pipelined master: each cycle checks the response owed to the transfer in its data phase.
  task automatic run();
    vec_t      ap, dp;
    bit        ap_v = 1'b0, dp_v = 1'b0;
    int        dp_cyc = 0, guard = 0;
    int        ws = ws_of(tgt);
    bit        r_exp, s_exp, chk_d;
    bit [31:0] d_exp;
    obs_low = 0; obs_rdata = '0; obs_err = 1'b0;
    if (xq.size() > 0) begin ap = xq.pop_front(); ap_v = 1'b1; end
    while ((ap_v || dp_v) && guard < 5000) begin
      guard++;
      @(negedge hclk);
      r_exp = 1'b1; s_exp = 1'b0; d_exp = '0; chk_d = 1'b1;
      if (dp_v) begin
        if (!is_legal(dp)) begin
          r_exp = (dp_cyc == 1);
          s_exp = 1'b1;
        end else begin
          r_exp = (dp_cyc == ws);
          if (r_exp && !dp.wr) begin
            d_exp = mmem[tgt][dp.addr / 4];
            chk_d = mok[tgt][dp.addr / 4];
          end
        end
      end
      if (!hreadyout_v[tgt]) obs_low++;
      chkb("hreadyout", hreadyout_v[tgt], r_exp);
      chkb("hresp", hresp_v[tgt], s_exp);
      if (chk_d) chk($sformatf("hrdata@%h", dp.addr), hrdata_v[tgt], d_exp);
      if (dp_v && r_exp) begin obs_rdata = hrdata_v[tgt]; obs_err = hresp_v[tgt]; end
      hwdata = dp_v ? dp.wdata : $urandom;
      hburst = 3'($urandom);
      if (ap_v) begin
        sel_b = ap.sel; ovr_lo = ap.hrdy_lo; htrans = ap.trans;
        hwrite = ap.wr; hsize = ap.size; haddr = ap.addr;
      end else idle_bus();
      if (r_exp) begin
        if (dp_v && is_legal(dp) && dp.wr) model_write(dp);
        dp_v = ap_v && ap.sel && ap.trans[1] && !ap.hrdy_lo;
        if (dp_v) begin dp = ap; dp_cyc = 0; end
        ap_v = 1'b0;
        if (xq.size() > 0) begin ap = xq.pop_front(); ap_v = 1'b1; end
      end else dp_cyc++;
    end
    if (guard >= 5000) chkb("run_bound", 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    vec_t      tbl[$];
    vec_t      v;
    bit [31:0] bdat [4];

    tbl.push_back(mk(1, 0, 2, 1, 2, 32'h000, 32'h0BADF00D, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 1, 2, 32'h008, 32'h11223344, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 1, 0, 32'h009, 32'h0000AA00, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 32'h008, 32'h0,        0, 32'h1122AA44));
    tbl.push_back(mk(1, 0, 2, 1, 1, 32'h00A, 32'h55660000, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 32'h008, 32'h0,        0, 32'h5566AA44));
    tbl.push_back(mk(1, 0, 2, 1, 2, 32'h002, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 3, 32'h000, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, 0, 2, 1, 2, 32'h400, 32'hFFFFFFFF, 1, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 32'h000, 32'h0,        0, 32'h0BADF00D));
    tbl.push_back(mk(1, 0, 0, 1, 2, 32'h000, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(1, 0, 1, 1, 2, 32'h000, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(1, 1, 2, 1, 2, 32'h000, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(0, 0, 2, 1, 2, 32'h000, 32'hFFFFFFFF, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 32'h000, 32'h0,        0, 32'h0BADF00D));
    tbl.push_back(mk(1, 0, 2, 0, 1, 32'h00B, 32'h0,        1, 32'h0));
    tbl.push_back(mk(1, 0, 2, 1, 2, 32'h3FC, 32'hA5A5A5A5, 0, 32'h0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 32'h3FC, 32'h0,        0, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 0, 3, 0, 0, 32'h3FF, 32'h0,        0, 32'hA5A5A5A5));

    hresetn = 1'b0; tgt = 0; hwdata = '0; hburst = '0; hprot = '0; hmastlock = 1'b0;
    idle_bus();
    repeat (3) @(negedge hclk);
    chkb("reset_hreadyout", hreadyout_v[0], 1'b1);
    chkb("reset_hresp", hresp_v[0], 1'b0);
    chk("reset_hrdata", hrdata_v[0], 32'h0);
    hresetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      xq.push_back(tbl[i]);
      run();
      chkb($sformatf("vec%0d_err", i), obs_err, tbl[i].exp_err);
      chk($sformatf("vec%0d_rdata", i), obs_rdata, tbl[i].exp_rdata);
    end

    xq.push_back(mk(1, 0, 2, 1, 2, 32'h004, 32'hDEADBEEF, 0, 0));
    xq.push_back(mk(1, 0, 2, 0, 2, 32'h004, 32'h0, 0, 0));
    run();
    chk("b2b_rdata", obs_rdata, 32'hDEADBEEF);
    chk("b2b_stall_cycles", obs_low, 32'd0);

    tgt = 1;
    for (int i = 0; i < 4; i++) begin
      bdat[i] = $urandom;
      xq.push_back(mk(1, 0, 2, 1, 2, 32'h20 + 4 * i, bdat[i], 0, 0));
    end
    run();
    for (int i = 0; i < 4; i++) xq.push_back(mk(1, 0, (i == 0) ? 2'd2 : 2'd3, 0, 2, 32'h20 + 4 * i, 0, 0, 0));
    run();
    chk("burst_stall_cycles", obs_low, 32'd8);
    chk("burst_last_beat", obs_rdata, bdat[3]);

    tgt = 2;
    xq.push_back(mk(1, 0, 2, 1, 2, 32'h10, 32'h12345678, 0, 0));
    run();
    @(negedge hclk);
    sel_b = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    @(negedge hclk);
    idle_bus(); hwdata = 32'hCAFEF00D;
    chkb("rst_mid_wait", hreadyout_v[2], 1'b0);
    #2 hresetn = 1'b0;
    #1;
    chkb("rst_async_hreadyout", hreadyout_v[2], 1'b1);
    chkb("rst_async_hresp", hresp_v[2], 1'b0);
    chk("rst_async_hrdata", hrdata_v[2], 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    xq.push_back(mk(1, 0, 2, 0, 2, 32'h10, 0, 0, 0));
    run();
    chk("rst_readback", obs_rdata, 32'h12345678);

    for (int t = 0; t < 2; t++) begin
      tgt = t;
      for (int i = 0; i < 16; i++) xq.push_back(mk(1, 0, 2, 1, 2, 4 * i, $urandom, 0, 0));
      run();
      for (int n = 0; n < 150; n++) begin
        v.sel     = ($urandom_range(0, 9) != 0);
        v.hrdy_lo = ($urandom_range(0, 15) == 0);
        v.trans   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        v.wr      = 1'($urandom_range(0, 1));
        v.size    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        case ($urandom_range(0, 9))
          0:       v.addr = 32'h400 + $urandom_range(0, 255);
          1:       v.addr = 32'h3FC + $urandom_range(0, 3);
          default: v.addr = $urandom_range(0, 63);
        endcase
        v.wdata = $urandom;
        xq.push_back(v);
      end
      run();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/peripheral_ahb3_sram_slave.md
# peripheral_ahb3_sram_slave

AHB3-Lite slave memory that sits directly downstream of the AHB3 bus interface used by the peripheral UVM environment: it consumes the master-driven address/control/write-data signals and produces hrdata, hreadyout and hresp. It is a word-addressed register-array SRAM with byte-lane writes, a programmable number of wait states and a two-cycle ERROR response for illegal accesses. It is the DUT the UVM agent drives.

## Interface
- HADDR_SIZE, 32, address width
- HDATA_SIZE, 32, data width (fixed 32 in this block)
- MEM_DEPTH, 256, number of 32-bit words; power of two
- WAIT_STATES, 0, extra hreadyout=0 cycles per NONSEQ/SEQ transfer (0..15)

- hclk  in  1  bus clock, all state on rising edge
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  HADDR_SIZE  byte address
- hwdata  in  HDATA_SIZE  write data (data phase)
- hwrite  in  1  1=write
- hsize  in  3  0=byte, 1=half, 2=word
- hburst  in  3  ignored (addresses arrive explicitly)
- hprot  in  4  ignored
- htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- hmastlock  in  1  ignored
- hready  in  1  bus-level ready (mux output)
- hrdata  out  HDATA_SIZE  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR

## Operation
- Address phase accepted when hsel & hready & htrans[1]; latch addr_q, write_q, size_q into data-phase registers. hsel & hready with htrans IDLE/BUSY: no transfer, zero-wait OKAY.
- Legality at acceptance: error if hsize>2, or misaligned (half with haddr[0]=1, word with haddr[1:0]!=0), or word index haddr[HADDR_SIZE-1:2] >= MEM_DEPTH. Erroneous transfer never touches memory.
- States: IDLE (no pending data phase), DATA (pending legal transfer), ERR1, ERR2.
- IDLE: hreadyout=1, hresp=0. Legal accept -> DATA with wcnt=WAIT_STATES; illegal accept -> ERR1.
- DATA: hreadyout=(wcnt==0), hresp=0, wcnt decrements while nonzero. In the cycle hreadyout=1: write commits at the closing edge using byte lanes derived from addr_q[1:0]/size_q (little-endian; byte lane i = hwdata[8i+7:8i]); read drives hrdata=mem[addr_q word] (full word, all lanes). Next state per new address phase sampled at that same edge (pipelined back-to-back, no bubble): legal -> DATA, illegal -> ERR1, none -> IDLE.
- ERR1: hreadyout=0, hresp=1; always -> ERR2.
- ERR2: hreadyout=1, hresp=1; address phase sampled as in IDLE.
- hrdata is 0 in all cycles other than a read data phase with hreadyout=1.
- Memory contents are not reset; only control state is.

## Timing
- Reset (async assert, sync-free deassert): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wcnt=0, data-phase registers cleared. Reset mid-transfer abandons it; any pending write is not committed.
- Zero-wait read latency: data valid in the cycle after the address phase. Each wait state adds one cycle.
- Write followed immediately by read of same word: write commits at the edge ending its data phase; following read data phase returns the new value (no forwarding needed).
- ERROR response is exactly two cycles regardless of WAIT_STATES.
- hsel deasserted during an in-progress data phase does not cancel it.
- hready low (another slave's wait) blocks acceptance; no state change in IDLE.

## Test plan
- Reset: hresetn=0 mid-DATA with WAIT_STATES=3 -> next cycle hreadyout=1, hresp=0, hrdata=0; prior pending write to 0x10 absent on readback.
- Word write 0xDEADBEEF to 0x04 then back-to-back read 0x04, WAIT_STATES=0 -> hrdata=0xDEADBEEF one cycle after read address phase, hreadyout never low.
- Byte write 0xAA to 0x09 over word 0x11223344 at 0x08 -> read 0x08 returns 0x1122AA44; half write 0x5566 to 0x0A -> 0x5566AA44.
- Illegal: word access to 0x02, hsize=3, and address 0x400 (MEM_DEPTH=256) -> each gives hreadyout=0/hresp=1 then hreadyout=1/hresp=1; memory unchanged.
- WAIT_STATES=2, 4-beat SEQ read burst 0x20..0x2C -> each beat shows two hreadyout=0 cycles then data; total 12 data-phase cycles.
- IDLE/BUSY with hsel=1, and hready=0 with NONSEQ -> no access, hreadyout=1, hresp=0.
